// File: rtl/rgb_lcd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rgb_lcd_ctrl
// Function : Parallel-RGB TFT driver: pixel clock, HS/VS/DE timing, 8-bar
//            colour pattern and panel reset / backlight power sequencing.
// Revision : 1.0
// ============================================================================
module rgb_lcd_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int RST_DLY  = 50000
) (
    input  logic        clk,
    input  logic        i_rst_n,
    output logic [23:0] o_rgb,
    output logic        o_rgb_clk,
    output logic        lcd_de,
    output logic        lcd_rst_n,
    output logic        lcd_bl,
    output logic        lcd_hs,
    output logic        lcd_vs
);

    localparam int c_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_BAR_W   = H_ACTIVE / 8;

    localparam int c_DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_HW  = $clog2(c_H_TOTAL);
    localparam int c_VW  = $clog2(c_V_TOTAL);
    localparam int c_PW  = $clog2(RST_DLY + 1);
    localparam int c_BXW = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;

    localparam logic [c_DW-1:0]  c_DIV_LAST    = c_DW'(CLK_DIV - 1);
    localparam logic [c_DW-1:0]  c_DIV_HALF    = c_DW'(CLK_DIV / 2);
    localparam logic [c_HW-1:0]  c_H_LAST      = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0]  c_H_SYNC_END  = c_HW'(H_SYNC);
    localparam logic [c_HW-1:0]  c_H_ACT_START = c_HW'(H_SYNC + H_BP);
    localparam logic [c_HW-1:0]  c_H_ACT_END   = c_HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [c_HW-1:0]  c_H_PRE_ACT   = c_HW'(H_SYNC + H_BP - 1);
    localparam logic [c_VW-1:0]  c_V_LAST      = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0]  c_V_SYNC_END  = c_VW'(V_SYNC);
    localparam logic [c_VW-1:0]  c_V_ACT_START = c_VW'(V_SYNC + V_BP);
    localparam logic [c_VW-1:0]  c_V_ACT_END   = c_VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [c_PW-1:0]  c_PWR_LAST    = c_PW'(RST_DLY - 1);
    localparam logic [c_BXW-1:0] c_BAR_LAST    = c_BXW'(c_BAR_W - 1);

    logic [c_DW-1:0]  r_div_cnt;
    logic [c_DW-1:0]  w_div_next;
    logic             w_pix_tick;
    logic             r_rgb_clk;

    logic [c_PW-1:0]  r_pwr_cnt;
    logic             r_pwr_done;

    logic [c_HW-1:0]  r_h_cnt;
    logic [c_VW-1:0]  r_v_cnt;
    logic [c_BXW-1:0] r_bar_px;
    logic [2:0]       r_bar;

    logic             w_h_act;
    logic             w_v_act;
    logic             w_de;
    logic [23:0]      w_bar_rgb;

    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic [23:0]      r_rgb;

    // ------------------------------------------------------------------------
    // Pixel clock divider. o_rgb_clk is derived from the next count so it is
    // high exactly while the count sits in the upper half of the period.
    // ------------------------------------------------------------------------
    assign w_pix_tick = (r_div_cnt == c_DIV_LAST);
    assign w_div_next = w_pix_tick ? '0 : r_div_cnt + 1'b1;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_rgb_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_rgb_clk <= (w_div_next >= c_DIV_HALF);
        end
    end

    // ------------------------------------------------------------------------
    // Panel reset / backlight release after RST_DLY clocks.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwr_cnt  <= '0;
            r_pwr_done <= 1'b0;
        end else if (!r_pwr_done) begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
            if (r_pwr_cnt == c_PWR_LAST) begin
                r_pwr_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Horizontal / vertical counters and bar tracker, advancing per pixel.
    // The bar tracker restarts one pixel before the active region so that at
    // any active h_cnt it already names that pixel's bar.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (w_pix_tick) begin
            if (r_h_cnt == c_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            if (r_h_cnt == c_H_PRE_ACT) begin
                r_bar_px <= '0;
                r_bar    <= '0;
            end else if (r_bar_px == c_BAR_LAST) begin
                r_bar_px <= '0;
                r_bar    <= r_bar + 1'b1;
            end else begin
                r_bar_px <= r_bar_px + 1'b1;
            end
        end
    end

    assign w_h_act = (r_h_cnt >= c_H_ACT_START) && (r_h_cnt < c_H_ACT_END);
    assign w_v_act = (r_v_cnt >= c_V_ACT_START) && (r_v_cnt < c_V_ACT_END);
    assign w_de    = w_h_act && w_v_act && r_pwr_done;

    always_comb begin
        w_bar_rgb = 24'h000000;
        case (r_bar)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode, updated only on pixel ticks so every panel signal moves
    // on the same clock, half a pixel period before the o_rgb_clk rise.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_de  <= 1'b0;
            r_rgb <= '0;
        end else if (w_pix_tick) begin
            r_hs  <= (r_h_cnt >= c_H_SYNC_END);
            r_vs  <= (r_v_cnt >= c_V_SYNC_END);
            r_de  <= w_de;
            r_rgb <= w_de ? w_bar_rgb : 24'h000000;
        end
    end

    assign o_rgb     = r_rgb;
    assign o_rgb_clk = r_rgb_clk;
    assign lcd_de    = r_de;
    assign lcd_rst_n = r_pwr_done;
    assign lcd_bl    = r_pwr_done;
    assign lcd_hs    = r_hs;
    assign lcd_vs    = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_rgb_lcd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rgb_lcd_ctrl
// Function : Self-checking bench for rgb_lcd_ctrl on a reduced panel geometry.
// Revision : 1.0
// ============================================================================
module tb_rgb_lcd_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int RST_DLY  = 300;

    localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [23:0] COLOURS [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] o_rgb;
    logic        o_rgb_clk;
    logic        lcd_de;
    logic        lcd_rst_n;
    logic        lcd_bl;
    logic        lcd_hs;
    logic        lcd_vs;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    bit chk_en = 1'b0;

    rgb_lcd_ctrl #(
        .CLK_DIV (CLK_DIV),  .H_SYNC (H_SYNC), .H_BP (H_BP),
        .H_ACTIVE(H_ACTIVE), .H_FP   (H_FP),   .V_SYNC (V_SYNC),
        .V_BP    (V_BP),     .V_ACTIVE(V_ACTIVE), .V_FP (V_FP),
        .RST_DLY (RST_DLY)
    ) dut (
        .clk      (clk),
        .i_rst_n  (rst_n),
        .o_rgb    (o_rgb),
        .o_rgb_clk(o_rgb_clk),
        .lcd_de   (lcd_de),
        .lcd_rst_n(lcd_rst_n),
        .lcd_bl   (lcd_bl),
        .lcd_hs   (lcd_hs),
        .lcd_vs   (lcd_vs)
    );

    always #10 clk = ~clk;

    // Number of rising clock edges since reset was last released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e <= 0;
        else        e <= e + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {rgb, rgb_clk, de, rst_n, bl, hs, vs} after `edges` clock edges.
    function automatic logic [29:0] model(input int edges);
        int          t, n, h, v, x;
        logic        pw, tick_pw, hs, vs, de, pclk;
        logic [23:0] rgb;
        pw   = (edges >= RST_DLY);
        pclk = ((edges % CLK_DIV) >= CLK_DIV / 2);
        t    = (edges / CLK_DIV) * CLK_DIV;
        hs = 1'b1; vs = 1'b1; de = 1'b0; rgb = 24'h0;
        if (t > 0) begin
            n       = t / CLK_DIV - 1;
            h       = n % HT;
            v       = (n / HT) % VT;
            tick_pw = ((t - 1) >= RST_DLY);
            hs      = (h >= H_SYNC);
            vs      = (v >= V_SYNC);
            x       = h - (H_SYNC + H_BP);
            de      = tick_pw && x >= 0 && x < H_ACTIVE &&
                      v >= V_SYNC + V_BP && v < V_SYNC + V_BP + V_ACTIVE;
            if (de) rgb = COLOURS[x / (H_ACTIVE / 8)];
        end
        return {rgb, pclk, de, pw, pw, hs, vs};
    endfunction

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_outputs",
                {o_rgb, o_rgb_clk, lcd_de, lcd_rst_n, lcd_bl, lcd_hs, lcd_vs},
                model(e));
    end

    function automatic logic [23:0] pick(input int sel);
        case (sel)
            0:       return {23'd0, lcd_hs};
            1:       return {23'd0, lcd_vs};
            2:       return {23'd0, lcd_de};
            3:       return {23'd0, lcd_rst_n};
            default: return o_rgb;
        endcase
    endfunction

    // Wait (bounded) for a signal to reach a value; check the edge count then.
    task automatic wait_for(input string name, input int sel, input logic [23:0] val,
                            input int budget, input int exp_e);
        int at;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pick(sel) == val) begin
                at = e;
                break;
            end
        end
        chk(name, at, exp_e);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #1000;
        chk("reset_vals", {o_rgb, o_rgb_clk, lcd_de, lcd_rst_n, lcd_bl, lcd_hs, lcd_vs},
            {24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        #5 rst_n = 1'b1;

        wait_for("hs_fall_first", 0, 24'd0, 20, 4);
        wait_for("hs_rise",       0, 24'd1, 40, 16);
        wait_for("hs_fall_line2", 0, 24'd0, 200, 96);
        wait_for("panel_rst_rise", 3, 24'd1, 400, RST_DLY);
        chk("backlight_on", lcd_bl, 1);
        wait_for("de_first_rise", 2, 24'd1, 40, 304);
        chk("px_bar0", o_rgb, 24'hFFFFFF);
        wait_for("bar1_start",    4, 24'hFFFF00, 40, 308);
        wait_for("de_fall_row",   2, 24'd0, 200, 364);
        wait_for("de_rise_row2",  2, 24'd1, 200, 392);
        chk("px_row2_bar0", o_rgb, 24'hFFFFFF);
        wait_for("vs_fall_frame2", 1, 24'd0, 1000, 740);
        wait_for("vs_rise_frame2", 1, 24'd1, 1000, 924);
        wait_for("de_rise_frame2", 2, 24'd1, 400, 1036);

        // Asynchronous reset pulse in the middle of an active line.
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_vals", {o_rgb, o_rgb_clk, lcd_de, lcd_rst_n, lcd_bl, lcd_hs, lcd_vs},
            {24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        #200 rst_n = 1'b1;

        wait_for("re_hs_fall",      0, 24'd0, 20, 4);
        wait_for("re_panel_rst",    3, 24'd1, 400, RST_DLY);
        wait_for("re_de_first",     2, 24'd1, 40, 304);
        repeat (800) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
